// File: rtl/han_carlson_pipe_adder_pkg.sv
// rtl/han_carlson_pipe_adder_pkg.sv - shared types and elaboration helpers for the Han-Carlson adder
// Purpose: prefix-cell types, the prefix-level count and the stage-to-level mapping.
// Ports: none (package).
package han_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // One level of odd black cells, clog2(W)-1 sparse Kogge-Stone levels, one grey level.
  function automatic int levels_for(input int width);
    return clog2(width) + 1;
  endfunction

  localparam int DEFAULT_WIDTH = 16;
  localparam int LEVELS        = levels_for(DEFAULT_WIDTH);

  // Prefix level after which pipeline stage k registers (level 0 = bitwise p/g).
  function automatic int stage_level(input int k, input int stages, input int levels);
    return (k * levels) / stages;
  endfunction

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic pg_t black(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // The group propagate is no longer needed once a position is fully prefixed.
  function automatic pg_t grey(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p;
    return r;
  endfunction

endpackage

// File: rtl/han_carlson_pipe_adder_if.sv
// rtl/han_carlson_pipe_adder_if.sv - input/result stream bundle of the Han-Carlson adder
// Purpose: groups the operand beat (in_*) and result beat (out_*) with their handshakes.
// Modports: master drives operands and out_ready; slave (the adder) drives in_ready and results.
interface han_carlson_pipe_adder_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
  );
endinterface

// File: rtl/han_carlson_pipe_adder_prefix_level.sv
// rtl/han_carlson_pipe_adder_prefix_level.sv - one combinational level of the Han-Carlson prefix tree
// Purpose: level 1 = odd-bit black cells, middle levels = Kogge-Stone spans over odd bits,
//          last level = grey cells filling the even bits.
// Ports: pg_i - prefix vector entering the level; pg_o - prefix vector leaving it.
module han_prefix_level
  import han_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEVEL = 1
) (
  input  pg_t [WIDTH-1:0] pg_i,
  output pg_t [WIDTH-1:0] pg_o
);
  localparam int LAST = levels_for(WIDTH);
  localparam int SPAN = 1 << (LEVEL - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (LEVEL == LAST && (i % 2) == 0 && i > 0) begin : g_grey
      assign pg_o[i] = grey(pg_i[i], pg_i[i-1]);
    end else if (LEVEL < LAST && (i % 2) == 1 && i >= SPAN) begin : g_black
      assign pg_o[i] = black(pg_i[i], pg_i[i-SPAN]);
    end else begin : g_pass
      assign pg_o[i] = pg_i[i];
    end
  end
endmodule

// File: rtl/han_carlson_pipe_adder.sv
// rtl/han_carlson_pipe_adder.sv - pipelined Han-Carlson adder/subtractor with valid/ready flow control
// Purpose: A + (sub ? ~B : B) + (sub ? ~cin : cin) with cout/ovf/zero flags and a sideband tag.
// Ports: clk, rst_n (async active-low); bus (slave) carries the in_* operand beat and out_* result beat.
module han_carlson_pipe_adder
  import han_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  han_carlson_pipe_adder_if.slave bus
);
  localparam int LV = levels_for(WIDTH);
  localparam int S  = PIPE_STAGES;

  // Values entering stage k; stage_load[S+1] is the downstream ready.
  logic             stage_load  [1:S+1];
  logic             stage_valid [1:S];
  pg_t [WIDTH-1:0]  stage_pg    [1:S];
  logic [WIDTH-1:0] stage_p     [1:S];
  logic             stage_c0    [1:S];
  logic [TAG_W-1:0] stage_tag   [1:S];

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic             c0_in;
  pg_t [WIDTH-1:0]  pg_in;

  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0_in = bus.in_sub ? ~bus.in_cin : bus.in_cin;
  assign p_in  = bus.in_a ^ b_eff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pg
    if (i == 0) begin : g_lsb
      // Carry-in folds into g[0] so the tree yields exact carries with no extra cell.
      assign pg_in[i] = '{g: (bus.in_a[0] & b_eff[0]) | (p_in[0] & c0_in), p: p_in[0]};
    end else begin : g_bit
      assign pg_in[i] = '{g: bus.in_a[i] & b_eff[i], p: p_in[i]};
    end
  end

  assign stage_valid[1]   = bus.in_valid;
  assign stage_pg[1]      = pg_in;
  assign stage_p[1]       = p_in;
  assign stage_c0[1]      = c0_in;
  assign stage_tag[1]     = bus.in_tag;
  assign stage_load[S+1]  = bus.out_ready;
  assign bus.in_ready     = stage_load[1];

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int LO = stage_level(k - 1, S, LV);
    localparam int HI = stage_level(k, S, LV);

    pg_t [WIDTH-1:0] node [LO:HI];
    logic            valid_q;

    assign node[LO] = stage_pg[k];
    for (genvar l = LO + 1; l <= HI; l++) begin : g_level
      han_prefix_level #(.WIDTH(WIDTH), .LEVEL(l)) u_level (
        .pg_i (node[l-1]),
        .pg_o (node[l])
      );
    end

    // A stage accepts when empty or when its current beat moves on this cycle.
    assign stage_load[k] = !valid_q || stage_load[k+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else if (stage_load[k]) begin
        valid_q <= stage_valid[k];
      end
    end

    if (k < S) begin : g_mid
      pg_t [WIDTH-1:0]  pg_q;
      logic [WIDTH-1:0] p_q;
      logic             c0_q;
      logic [TAG_W-1:0] tag_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pg_q  <= '0;
          p_q   <= '0;
          c0_q  <= 1'b0;
          tag_q <= '0;
        end else if (stage_load[k]) begin
          pg_q  <= node[HI];
          p_q   <= stage_p[k];
          c0_q  <= stage_c0[k];
          tag_q <= stage_tag[k];
        end
      end

      assign stage_valid[k+1] = valid_q;
      assign stage_pg[k+1]    = pg_q;
      assign stage_p[k+1]     = p_q;
      assign stage_c0[k+1]    = c0_q;
      assign stage_tag[k+1]   = tag_q;
    end else begin : g_last
      // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
      logic [WIDTH:0]   carry;
      logic [WIDTH-1:0] sum_d, sum_q;
      logic             cout_d, cout_q;
      logic             ovf_d, ovf_q;
      logic             zero_d, zero_q;
      logic [TAG_W-1:0] tag_q;

      assign carry[0] = stage_c0[k];
      for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
        assign carry[i] = node[HI][i-1].g;
      end

      assign sum_d  = stage_p[k] ^ carry[WIDTH-1:0];
      assign cout_d = carry[WIDTH];
      assign ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
      assign zero_d = (sum_d == '0);

      // Zero is registered too so the whole output word reads 0 out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          tag_q  <= '0;
        end else if (stage_load[k]) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
          tag_q  <= stage_tag[k];
        end
      end

      assign bus.out_valid = valid_q;
      assign bus.out_sum   = sum_q;
      assign bus.out_cout  = cout_q;
      assign bus.out_ovf   = ovf_q;
      assign bus.out_zero  = zero_q;
      assign bus.out_tag   = tag_q;
    end
  end
endmodule

// File: tb/tb_han_carlson_pipe_adder.sv
// tb/tb_han_carlson_pipe_adder.sv - self-checking bench for han_carlson_pipe_adder
module tb_han_carlson_pipe_adder;
  localparam int W  = 16;
  localparam int S  = 2;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  han_carlson_pipe_adder_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  han_carlson_pipe_adder #(.WIDTH(W), .PIPE_STAGES(S), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
    int            stamp;
    bit            chk_lat;
  } exp_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  bit   saw_in_ready_low;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic sub, input logic [TW-1:0] tag, input bit chk_lat);
    exp_t        e;
    logic [W:0]  full;
    int          sa, sbv, ci, ex;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    ci  = int'(cin);
    if (!sub) begin
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.cout = full[W];
      ex     = sa + sbv + ci;
    end else begin
      full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      e.cout = ~full[W];
      ex     = sa - sbv - ci;
    end
    e.sum     = full[W-1:0];
    e.ovf     = (ex > (2 ** (W - 1)) - 1) || (ex < -(2 ** (W - 1)));
    e.zero    = (full[W-1:0] == '0);
    e.tag     = tag;
    e.stamp   = 0;
    e.chk_lat = chk_lat;
    return e;
  endfunction

  // Scoreboard pop / compare and stall-stability check, sampled on the falling edge.
  initial begin
    exp_t          e;
    bit            held = 0;
    logic [W-1:0]  h_sum;
    logic [TW-1:0] h_tag;
    logic          h_cout, h_ovf, h_zero;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
          check("stall_sum", {48'd0, bus.out_sum}, {48'd0, h_sum});
          check("stall_flags", {61'd0, bus.out_cout, bus.out_ovf, bus.out_zero},
                {61'd0, h_cout, h_ovf, h_zero});
          check("stall_tag", {60'd0, bus.out_tag}, {60'd0, h_tag});
        end
        held = 0;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tag %0h expected no beat", bus.out_tag);
          end else begin
            e = sb.pop_front();
            pops++;
            check("sum", {48'd0, bus.out_sum}, {48'd0, e.sum});
            check("cout", {63'd0, bus.out_cout}, {63'd0, e.cout});
            check("ovf", {63'd0, bus.out_ovf}, {63'd0, e.ovf});
            check("zero", {63'd0, bus.out_zero}, {63'd0, e.zero});
            check("tag", {60'd0, bus.out_tag}, {60'd0, e.tag});
            if (e.chk_lat) check("latency", 64'(cyc - e.stamp), 64'(S));
          end
        end else if (bus.out_valid) begin
          held   = 1;
          h_sum  = bus.out_sum;
          h_tag  = bus.out_tag;
          h_cout = bus.out_cout;
          h_ovf  = bus.out_ovf;
          h_zero = bus.out_zero;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input logic [TW-1:0] tag, input exp_t e);
    bit ok;
    ok = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 100 cycles");
    end else begin
      e.stamp = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom);
    bus.in_sub   = 1'($urandom);
    bus.in_tag   = TW'($urandom);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(output logic [W-1:0] a, output logic [W-1:0] b,
                          output logic cin, output logic sub);
    logic [W-1:0] corner[4];
    corner[0] = '0;
    corner[1] = '1;
    corner[2] = {1'b1, {(W-1){1'b0}}};
    corner[3] = {1'b0, {(W-1){1'b1}}};
    a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
    b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  initial begin
    exp_t         e;
    int           pops0, t0;
    bit           done;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    vecs[0] = '{a:16'hFFFF, b:16'h0001, cin:0, sub:0, tag:4'h1, sum:16'h0000, cout:1, ovf:0, zero:1};
    vecs[1] = '{a:16'h7FFF, b:16'h0001, cin:0, sub:0, tag:4'h2, sum:16'h8000, cout:0, ovf:1, zero:0};
    vecs[2] = '{a:16'h0005, b:16'h0007, cin:0, sub:1, tag:4'h3, sum:16'hFFFE, cout:0, ovf:0, zero:0};
    vecs[3] = '{a:16'h1234, b:16'h4321, cin:1, sub:0, tag:4'h4, sum:16'h5556, cout:0, ovf:0, zero:0};
    vecs[4] = '{a:16'h8000, b:16'h0001, cin:0, sub:1, tag:4'h5, sum:16'h7FFF, cout:1, ovf:1, zero:0};
    vecs[5] = '{a:16'h0003, b:16'h0003, cin:0, sub:1, tag:4'h6, sum:16'h0000, cout:1, ovf:0, zero:1};
    vecs[6] = '{a:16'h0000, b:16'h0000, cin:1, sub:1, tag:4'h7, sum:16'hFFFF, cout:0, ovf:0, zero:0};
    vecs[7] = '{a:16'h8000, b:16'h8000, cin:0, sub:0, tag:4'h8, sum:16'h0000, cout:1, ovf:1, zero:1};
    vecs[8] = '{a:16'hFFFF, b:16'hFFFF, cin:1, sub:0, tag:4'h9, sum:16'hFFFF, cout:1, ovf:0, zero:0};
    vecs[9] = '{a:16'hAAAA, b:16'h5555, cin:1, sub:0, tag:4'hA, sum:16'h0000, cout:1, ovf:0, zero:1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_sum", {48'd0, bus.out_sum}, 64'd0);
    check("rst_out_flags", {61'd0, bus.out_cout, bus.out_ovf, bus.out_zero}, 64'd0);
    check("rst_out_tag", {60'd0, bus.out_tag}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Directed vector table, one beat at a time with latency check
    for (int i = 0; i < 10; i++) begin
      e = '{sum:vecs[i].sum, cout:vecs[i].cout, ovf:vecs[i].ovf, zero:vecs[i].zero,
            tag:vecs[i].tag, stamp:0, chk_lat:1'b1};
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].tag, e);
      drain("vec_drain");
    end

    // Back-to-back burst with no stall: one beat per cycle, latency S each
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      rand_ops(ra, rb, rc, rs);
      send(ra, rb, rc, rs, TW'(i), model(ra, rb, rc, rs, TW'(i), 1'b1));
    end
    check("burst_throughput", 64'(cyc - t0), 64'd20);
    drain("burst_drain");

    // 8-beat stream with out_ready low for cycles 3..6
    pops0 = pops;
    saw_in_ready_low = 0;
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          rand_ops(ra, rb, rc, rs);
          send(ra, rb, rc, rs, TW'(t), model(ra, rb, rc, rs, TW'(t), 1'b0));
        end
      end
      begin
        for (int c = 0; c < 12; c++) begin
          bus.out_ready = !(c >= 3 && c <= 6);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          if (!bus.in_ready) saw_in_ready_low = 1;
        end
      end
    join
    drain("stream_drain");
    check("stream_in_ready_fell", {63'd0, saw_in_ready_low}, 64'd1);
    check("stream_beat_count", 64'(pops - pops0), 64'd8);

    // Reset with two beats in flight
    e = model(16'h1111, 16'h2222, 1'b0, 1'b0, 4'hB, 1'b0);
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 4'hB, e);
    e = model(16'h3333, 16'h4444, 1'b0, 1'b0, 4'hC, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0, 4'hC, e);
    check("pre_rst_out_valid", {63'd0, bus.out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_out_sum", {48'd0, bus.out_sum}, 64'd0);
    check("async_rst_out_flags", {61'd0, bus.out_cout, bus.out_ovf, bus.out_zero}, 64'd0);
    check("async_rst_out_tag", {60'd0, bus.out_tag}, 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    e = '{sum:16'h0007, cout:1'b0, ovf:1'b0, zero:1'b0, tag:4'hD, stamp:0, chk_lat:1'b1};
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 4'hD, e);
    drain("rerst_drain");

    // Random beats with random input gaps and random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          rand_ops(ra, rb, rc, rs);
          send(ra, rb, rc, rs, TW'(i), model(ra, rb, rc, rs, TW'(i), 1'b0));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
